user_ddr_strm_requester: RTL and testbench

Per-user-port DDR stream engine. It sits on one slave port of the user DDR stream arbitrator and converts a read command (address, beat count) into a sequence of DDR read requests. Returned read data is delivered on an AXI4-Stream master. In the other direction it converts an AXI4-Stream slave plus a write command into DDR write requests. It is the initiator counterpart of the arbitrator's per-slave rd/wr req/ack ports.

---
 rtl/user_ddr_strm_requester.sv | 154 +++++++++++++++
 tb/tb_user_ddr_strm_requester.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_ddr_strm_requester.sv
// user_ddr_strm_requester: turns read/write commands into DDR req/ack transactions bridged to AXI4-Stream
module user_ddr_strm_requester #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 256,
  parameter int BE_WIDTH      = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int RD_FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_start,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [LEN_WIDTH-1:0]  i_rd_len,
  output logic                  o_rd_busy,
  output logic                  o_rd_done,
  output logic                  o_strm_tvalid,
  input  logic                  i_strm_tready,
  output logic [DATA_WIDTH-1:0] o_strm_tdata,
  input  logic                  i_wr_start,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [LEN_WIDTH-1:0]  i_wr_len,
  output logic                  o_wr_busy,
  output logic                  o_wr_done,
  input  logic                  i_strm_tvalid,
  output logic                  o_strm_tready,
  input  logic [DATA_WIDTH-1:0] i_strm_tdata,
  output logic                  o_ddr_rd_req,
  input  logic                  i_ddr_rd_ack,
  output logic [ADDR_WIDTH-1:0] o_ddr_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_ddr_rd_data,
  input  logic                  i_ddr_rd_data_valid,
  output logic                  o_ddr_wr_req,
  input  logic                  i_ddr_wr_ack,
  output logic [ADDR_WIDTH-1:0] o_ddr_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ddr_wr_data,
  output logic [BE_WIDTH-1:0]   o_ddr_wr_be_n
);
  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = PW + 2;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BE_WIDTH);

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_DRAIN} rd_state_e;
  typedef enum logic {WR_IDLE, WR_ACTIVE} wr_state_e;

  rd_state_e rd_st, rd_st_nx;
  wr_state_e wr_st, wr_st_nx;

  logic [LEN_WIDTH-1:0]  req_left, pop_left, acc_left, ack_left;
  logic [NW-1:0]         outst, wptr, rptr, fifo_cnt;
  logic [CW-1:0]         credit;
  logic [DATA_WIDTH-1:0] mem [RD_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_next;
  logic rd_ack_hit, rd_last_ack, push, pop, rd_last_pop, rd_can_req, rd_zero;
  logic wr_beat, wr_ack_hit, wr_last_ack, wr_zero;

  assign rd_ack_hit  = o_ddr_rd_req & i_ddr_rd_ack;
  assign rd_last_ack = rd_ack_hit & (req_left == LEN_WIDTH'(1));
  assign push        = i_ddr_rd_data_valid & (rd_st != RD_IDLE);
  assign pop         = o_strm_tvalid & i_strm_tready;
  assign rd_last_pop = pop & (pop_left == LEN_WIDTH'(1));
  assign rd_zero     = (rd_st == RD_IDLE) & i_rd_start & (i_rd_len == '0);
  assign fifo_cnt    = wptr - rptr;
  // outstanding plus buffered beats bound the FIFO so returns can never overflow
  assign credit      = CW'(outst) + CW'(fifo_cnt);
  assign rd_can_req  = (rd_st == RD_REQ) & !o_ddr_rd_req & (req_left != '0) & (credit < CW'(RD_FIFO_DEPTH));
  assign o_rd_busy     = rd_st != RD_IDLE;
  assign o_strm_tvalid = fifo_cnt != '0;
  assign o_strm_tdata  = o_strm_tvalid ? mem[rptr[PW-1:0]] : '0;

  assign wr_ack_hit    = o_ddr_wr_req & i_ddr_wr_ack;
  assign wr_last_ack   = wr_ack_hit & (ack_left == LEN_WIDTH'(1));
  assign wr_zero       = (wr_st == WR_IDLE) & i_wr_start & (i_wr_len == '0);
  assign o_strm_tready = (wr_st == WR_ACTIVE) & (acc_left != '0) & (!o_ddr_wr_req | i_ddr_wr_ack);
  assign wr_beat       = i_strm_tvalid & o_strm_tready;
  assign o_wr_busy     = wr_st != WR_IDLE;
  assign o_ddr_wr_be_n = '0;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rd_st <= RD_IDLE;
      wr_st <= WR_IDLE;
    end else begin
      rd_st <= rd_st_nx;
      wr_st <= wr_st_nx;
    end

  always_comb begin
    rd_st_nx = rd_st;
    wr_st_nx = wr_st;
    if (rd_st == RD_IDLE && i_rd_start && i_rd_len != '0) rd_st_nx = RD_REQ;
    else if (rd_st == RD_REQ && rd_last_ack) rd_st_nx = RD_DRAIN;
    else if (rd_st == RD_DRAIN && rd_last_pop) rd_st_nx = RD_IDLE;
    if (wr_st == WR_IDLE && i_wr_start && i_wr_len != '0) wr_st_nx = WR_ACTIVE;
    else if (wr_st == WR_ACTIVE && wr_last_ack) wr_st_nx = WR_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_ddr_rd_req  <= 1'b0;
      o_ddr_rd_addr <= '0;
      o_rd_done     <= 1'b0;
      req_left      <= '0;
      pop_left      <= '0;
      outst         <= '0;
      wptr          <= '0;
      rptr          <= '0;
    end else begin
      o_rd_done    <= rd_zero | ((rd_st == RD_DRAIN) & rd_last_pop);
      o_ddr_rd_req <= rd_ack_hit ? 1'b0 : (o_ddr_rd_req | rd_can_req);
      outst        <= outst + NW'(rd_ack_hit) - NW'(push);
      if (push) wptr <= wptr + NW'(1);
      if (pop) rptr <= rptr + NW'(1);
      if (rd_st == RD_IDLE && i_rd_start) begin
        o_ddr_rd_addr <= i_rd_addr;
        req_left      <= i_rd_len;
        pop_left      <= i_rd_len;
      end else begin
        if (rd_ack_hit) o_ddr_rd_addr <= o_ddr_rd_addr + STEP;
        if (rd_ack_hit) req_left <= req_left - LEN_WIDTH'(1);
        if (pop) pop_left <= pop_left - LEN_WIDTH'(1);
      end
    end

  always_ff @(posedge i_clk)
    if (push) mem[wptr[PW-1:0]] <= i_ddr_rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_ddr_wr_req  <= 1'b0;
      o_ddr_wr_addr <= '0;
      o_ddr_wr_data <= '0;
      o_wr_done     <= 1'b0;
      wr_next       <= '0;
      acc_left      <= '0;
      ack_left      <= '0;
    end else begin
      o_wr_done    <= wr_zero | wr_last_ack;
      o_ddr_wr_req <= wr_beat | (o_ddr_wr_req & !i_ddr_wr_ack);
      if (wr_st == WR_IDLE && i_wr_start) begin
        wr_next  <= i_wr_addr;
        acc_left <= i_wr_len;
        ack_left <= i_wr_len;
      end else begin
        if (wr_beat) begin
          o_ddr_wr_data <= i_strm_tdata;
          o_ddr_wr_addr <= wr_next;
          wr_next       <= wr_next + STEP;
          acc_left      <= acc_left - LEN_WIDTH'(1);
        end
        if (wr_ack_hit) ack_left <= ack_left - LEN_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_user_ddr_strm_requester.sv
// tb_user_ddr_strm_requester: randomized bench with a queue-based DDR/stream reference model
module tb_user_ddr_strm_requester;
  localparam int AW = 32, DW = 256, BW = 32, LW = 16, DEPTH = 16;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic i_rd_start = 1'b0, i_wr_start = 1'b0;
  logic [AW-1:0] i_rd_addr = '0, i_wr_addr = '0;
  logic [LW-1:0] i_rd_len = '0, i_wr_len = '0;
  logic o_rd_busy, o_rd_done, o_strm_tvalid, o_wr_busy, o_wr_done, o_strm_tready;
  logic i_strm_tready, i_strm_tvalid, i_ddr_rd_ack, i_ddr_rd_data_valid;
  logic [DW-1:0] o_strm_tdata, i_strm_tdata, i_ddr_rd_data, o_ddr_wr_data;
  logic o_ddr_rd_req, o_ddr_wr_req;
  logic [AW-1:0] o_ddr_rd_addr, o_ddr_wr_addr;
  logic [BW-1:0] o_ddr_wr_be_n;
  logic i_ddr_wr_ack, wr_tie = 1'b0, wr_ack_drv;

  assign i_ddr_wr_ack = wr_tie ? o_ddr_wr_req : wr_ack_drv;
  always #5 i_clk = ~i_clk;

  user_ddr_strm_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LEN_WIDTH(LW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rd_start(i_rd_start), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
    .o_rd_busy(o_rd_busy), .o_rd_done(o_rd_done),
    .o_strm_tvalid(o_strm_tvalid), .i_strm_tready(i_strm_tready), .o_strm_tdata(o_strm_tdata),
    .i_wr_start(i_wr_start), .i_wr_addr(i_wr_addr), .i_wr_len(i_wr_len),
    .o_wr_busy(o_wr_busy), .o_wr_done(o_wr_done),
    .i_strm_tvalid(i_strm_tvalid), .o_strm_tready(o_strm_tready), .i_strm_tdata(i_strm_tdata),
    .o_ddr_rd_req(o_ddr_rd_req), .i_ddr_rd_ack(i_ddr_rd_ack), .o_ddr_rd_addr(o_ddr_rd_addr),
    .i_ddr_rd_data(i_ddr_rd_data), .i_ddr_rd_data_valid(i_ddr_rd_data_valid),
    .o_ddr_wr_req(o_ddr_wr_req), .i_ddr_wr_ack(i_ddr_wr_ack), .o_ddr_wr_addr(o_ddr_wr_addr),
    .o_ddr_wr_data(o_ddr_wr_data), .o_ddr_wr_be_n(o_ddr_wr_be_n)
  );

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wbeat_t;
  typedef struct {logic [AW-1:0] a; int due;} ret_t;

  logic [AW-1:0] exp_rd_addr[$];
  logic [DW-1:0] exp_rd_data[$];
  wbeat_t        exp_wr[$];
  logic [DW-1:0] src_q[$];
  ret_t          ret_q[$];
  wbeat_t        wb_m;
  logic [AW-1:0] wr_next, p_raddr, p_waddr;
  logic [DW-1:0] p_wdata;
  logic wr_hs = 1'b0, p_rreq = 1'b0, p_rack = 1'b0, p_wreq = 1'b0, p_wack = 1'b0;
  int errors = 0, checks = 0, cyc = 0;
  int acked = 0, popped = 0, wr_acks = 0, wr_first = 0, wr_last = 0, rd_done_n = 0, wr_done_n = 0;
  int rlo = 0, rhi = 3, dlo = 0, dhi = 4, wlo = 0, whi = 3, tready_pct = 100, tvalid_pct = 100;
  int rd0, wr0;

  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_pat(logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = (a * 32'd3 + 32'(k)) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // DDR slave and stream partner: everything driven just after the rising edge
  initial begin
    int rcnt, wcnt, rdly, wdly;
    rcnt = 0; wcnt = 0; rdly = 0; wdly = 0;
    i_ddr_rd_ack = 0; i_ddr_rd_data_valid = 0; i_ddr_rd_data = '0; wr_ack_drv = 0;
    i_strm_tready = 0; i_strm_tvalid = 0; i_strm_tdata = '0;
    forever begin
      @(posedge i_clk); #1;
      cyc++;
      i_ddr_rd_data_valid = 0;
      if (!i_rst_n) begin
        i_ddr_rd_ack = 0; wr_ack_drv = 0; i_strm_tvalid = 0; rcnt = 0; wcnt = 0;
        continue;
      end
      if (i_ddr_rd_ack) i_ddr_rd_ack = 0;
      else if (o_ddr_rd_req) begin
        if (rcnt >= rdly) begin
          i_ddr_rd_ack = 1;
          ret_q.push_back('{o_ddr_rd_addr, cyc + 1 + $urandom_range(dhi, dlo)});
          rcnt = 0;
          rdly = $urandom_range(rhi, rlo);
        end else rcnt++;
      end
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        i_ddr_rd_data_valid = 1;
        i_ddr_rd_data = rd_pat(ret_q[0].a);
        void'(ret_q.pop_front());
      end
      if (wr_ack_drv) wr_ack_drv = 0;
      else if (o_ddr_wr_req) begin
        if (wcnt >= wdly) begin
          wr_ack_drv = 1; wcnt = 0; wdly = $urandom_range(whi, wlo);
        end else wcnt++;
      end
      i_strm_tready = $urandom_range(99, 0) < tready_pct;
      if (wr_hs && src_q.size() > 0) void'(src_q.pop_front());
      if (!(i_strm_tvalid && !wr_hs)) begin
        i_strm_tvalid = src_q.size() > 0 && $urandom_range(99, 0) < tvalid_pct;
        i_strm_tdata = src_q.size() > 0 ? src_q[0] : '0;
      end
    end
  end

  // Monitor on the falling edge: scoreboard and protocol rules
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      wr_hs = 0; p_rreq = 0; p_wreq = 0;
    end else begin
      wr_hs = i_strm_tvalid && o_strm_tready;
      if (wr_hs) begin
        exp_wr.push_back('{wr_next, i_strm_tdata});
        wr_next += BW;
      end
      if (p_rreq && !p_rack) check("rd_hold", {o_ddr_rd_req, o_ddr_rd_addr}, {1'b1, p_raddr});
      if (p_wreq && !p_wack) begin
        check("wr_hold_addr", {o_ddr_wr_req, o_ddr_wr_addr}, {1'b1, p_waddr});
        check("wr_hold_data", o_ddr_wr_data, p_wdata);
      end
      if (o_ddr_rd_req && i_ddr_rd_ack) begin
        if (exp_rd_addr.size() == 0) check("rd_extra_req", 1, 0);
        else check("rd_addr", o_ddr_rd_addr, exp_rd_addr.pop_front());
        acked++;
        check("rd_credit", (acked - popped) <= DEPTH, 1);
      end
      if (o_strm_tvalid && i_strm_tready) begin
        if (exp_rd_data.size() == 0) check("rd_extra_beat", 1, 0);
        else check("rd_data", o_strm_tdata, exp_rd_data.pop_front());
        popped++;
      end
      if (o_ddr_wr_req && i_ddr_wr_ack) begin
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else begin
          wb_m = exp_wr.pop_front();
          check("wr_addr", o_ddr_wr_addr, wb_m.a);
          check("wr_data", o_ddr_wr_data, wb_m.d);
        end
        check("wr_be_n", o_ddr_wr_be_n, 0);
        if (wr_acks == 0) wr_first = cyc;
        wr_last = cyc;
        wr_acks++;
      end
      if (o_ddr_wr_req && !i_ddr_wr_ack) check("wr_tready_low", o_strm_tready, 0);
      if (o_rd_done) rd_done_n++;
      if (o_wr_done) wr_done_n++;
      p_rreq = o_ddr_rd_req; p_rack = i_ddr_rd_ack; p_raddr = o_ddr_rd_addr;
      p_wreq = o_ddr_wr_req; p_wack = i_ddr_wr_ack; p_waddr = o_ddr_wr_addr; p_wdata = o_ddr_wr_data;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic cmd(bit do_rd, logic [AW-1:0] ra, int rl, bit do_wr, logic [AW-1:0] wa, int wl);
    if (do_rd)
      for (int i = 0; i < rl; i++) begin
        exp_rd_addr.push_back(ra + AW'(i * BW));
        exp_rd_data.push_back(rd_pat(ra + AW'(i * BW)));
      end
    if (do_wr) begin
      wr_next = wa;
      for (int i = 0; i < wl; i++) src_q.push_back(rnd_beat());
    end
    acked = 0; popped = 0; wr_acks = 0; rd0 = rd_done_n; wr0 = wr_done_n;
    tick(1);
    i_rd_start = do_rd; i_rd_addr = ra; i_rd_len = LW'(rl);
    i_wr_start = do_wr; i_wr_addr = wa; i_wr_len = LW'(wl);
    tick(1);
    i_rd_start = 0; i_wr_start = 0;
  endtask

  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while ((o_rd_busy || o_wr_busy) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
    tick(2);
  endtask

  task automatic check_rst_outputs(string tag);
    check({tag, "_ctl"}, {o_rd_busy, o_rd_done, o_strm_tvalid, o_wr_busy, o_wr_done, o_strm_tready,
                          o_ddr_rd_req, o_ddr_wr_req, o_ddr_wr_be_n}, 0);
    check({tag, "_addr"}, {o_ddr_rd_addr, o_ddr_wr_addr}, 0);
    check({tag, "_tdata"}, o_strm_tdata, 0);
    check({tag, "_wdata"}, o_ddr_wr_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check_rst_outputs("reset");
    i_rst_n = 1;
    tick(2);

    rlo = 1; rhi = 1; dlo = 2; dhi = 2;
    cmd(1, 32'h1000, 4, 0, 0, 0);
    wait_idle("t1", 200);
    check("t1_rd_done", rd_done_n - rd0, 1);
    check("t1_beats", popped, 4);
    check("t1_left", exp_rd_addr.size() + exp_rd_data.size(), 0);

    rlo = 0; rhi = 2; dlo = 0; dhi = 3; tready_pct = 0;
    cmd(1, 32'h8000, 40, 0, 0, 0);
    tick(150);
    check("t2_acked_at_stall", acked, DEPTH);
    check("t2_req_low", o_ddr_rd_req, 0);
    check("t2_tvalid", o_strm_tvalid, 1);
    tready_pct = 100;
    wait_idle("t2", 2000);
    check("t2_beats", popped, 40);
    check("t2_rd_done", rd_done_n - rd0, 1);

    wr_tie = 1;
    cmd(0, 0, 0, 1, 32'h200, 3);
    wait_idle("t3", 200);
    check("t3_acks", wr_acks, 3);
    check("t3_one_per_cycle", wr_last - wr_first, 2);
    check("t3_wr_done", wr_done_n - wr0, 1);
    check("t3_left", exp_wr.size() + src_q.size(), 0);
    wr_tie = 0;

    wlo = 5; whi = 5; tvalid_pct = 60;
    cmd(0, 0, 0, 1, 32'h4000, 6);
    wait_idle("t4", 500);
    check("t4_acks", wr_acks, 6);
    check("t4_wr_done", wr_done_n - wr0, 1);
    check("t4_left", exp_wr.size() + src_q.size(), 0);

    wlo = 0; whi = 3; tready_pct = 70;
    cmd(1, 32'hFFFF_FFE0, 2, 0, 0, 0);
    wait_idle("t5", 200);
    check("t5_wrap_beats", popped, 2);
    check("t5_rd_done", rd_done_n - rd0, 1);
    cmd(1, 32'h40, 0, 1, 32'h80, 0);
    @(negedge i_clk);
    check("t5_zero_done", {o_rd_done, o_wr_done}, 2'b11);
    check("t5_zero_busy", {o_rd_busy, o_wr_busy}, 0);
    tick(3);
    check("t5_zero_no_req", acked + wr_acks, 0);
    check("t5_zero_done_cnt", (rd_done_n - rd0) * 16 + (wr_done_n - wr0), 17);

    for (int it = 0; it < 5; it++) begin
      logic [AW-1:0] ra, wa;
      int rl, wl;
      ra = $urandom & ~32'h1F; wa = $urandom & ~32'h1F;
      rl = $urandom_range(24, 1); wl = $urandom_range(12, 1);
      tready_pct = $urandom_range(100, 30); tvalid_pct = $urandom_range(100, 30);
      cmd(1, ra, rl, 1, wa, wl);
      wait_idle("t6", 3000);
      check("t6_beats", popped, rl);
      check("t6_wr_acks", wr_acks, wl);
      check("t6_dones", (rd_done_n - rd0) * 16 + (wr_done_n - wr0), 17);
    end

    tready_pct = 70; tvalid_pct = 70;
    cmd(1, 32'h2_0000, 8, 1, 32'h3_0000, 8);
    tick($urandom_range(14, 6));
    #2;
    i_rst_n = 0;
    #1;
    check_rst_outputs("t7_async");
    exp_rd_addr.delete(); exp_rd_data.delete(); exp_wr.delete(); src_q.delete();
    tick(2);
    i_rst_n = 1;
    popped = 0;
    tick(12);
    check("t7_no_stale", {o_rd_busy, o_strm_tvalid, 30'(popped)}, 0);
    tready_pct = 100;
    cmd(1, 32'h500, 2, 0, 0, 0);
    wait_idle("t7", 200);
    check("t7_beats", popped, 2);
    check("t7_rd_done", rd_done_n - rd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
